sys_gather: RTL

- Receiving end of the serial column-sum stream produced by the systolic summation stage.
- That stream is one BitSize word per valid cycle, highest nerve index first, with a start flag on the first word.
- This block collects NumOfNerves consecutive words back into one parallel vector and presents it for one cycle.
- It counts vectors into frames of DepthOut vectors for the next layer, and flags protocol violations.

---
 rtl/sys_pkg.sv | 14 +
 rtl/sys_gather.sv | 89 ++++++++
 2 files changed

// File: rtl/sys_pkg.sv
// Shared types for the column-sum gather stage.
// State encoding and counter-width helper.
package sys_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sys_gather.sv
// Collects the serial column-sum stream back into
// parallel vectors and counts them into output frames.
module sys_gather
  import sys_pkg::*;
#(
  parameter int BitSize     = 8,
  parameter int NumOfNerves = 4,
  parameter int DepthOut    = 2
) (
  input  logic clk,
  input  logic res,
  input  logic in_valid,
  input  logic in_start,
  input  logic [BitSize-1:0] in_data,
  output logic out_valid,
  output logic out_start,
  output logic [NumOfNerves-1:0][BitSize-1:0] out_data,
  output logic out_error
);

  localparam int CW = clog2p1(NumOfNerves);
  localparam int VW = clog2p1(DepthOut);
  localparam logic [CW-1:0] TOP = CW'(NumOfNerves - 1);
  localparam logic [VW-1:0] VLAST = VW'(DepthOut - 1);

  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] slot;
  logic [VW-1:0] vcnt;
  logic [NumOfNerves-1:0][BitSize-1:0] fill;
  logic [NumOfNerves-1:0][BitSize-1:0] nxt;
  logic wr;
  logic last;
  logic bad;

  // Highest nerve index arrives first, so slots fill downward.
  always_comb begin
    slot = in_start ? TOP : TOP - cnt;
    wr   = in_valid & (in_start | (state == FILL));
    last = 1'b0;
    if (wr) begin
      if (in_start) last = (NumOfNerves == 1);
      else          last = (cnt == TOP);
    end
    bad = 1'b0;
    if (in_valid) begin
      if (in_start) bad = (state == FILL);
      else          bad = (state == IDLE);
    end
    nxt = fill;
    for (int i = 0; i < NumOfNerves; i++) begin
      if (slot == CW'(i)) nxt[i] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      cnt       <= '0;
      vcnt      <= '0;
      fill      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_error <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
      if (bad) out_error <= 1'b1;
      if (wr) begin
        fill <= nxt;
        if (last) begin
          out_data  <= nxt;
          out_valid <= 1'b1;
          out_start <= (vcnt == '0);
          vcnt      <= (vcnt == VLAST) ? '0
                       : vcnt + VW'(1);
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          cnt   <= in_start ? CW'(1)
                   : cnt + CW'(1);
          state <= FILL;
        end
      end
    end
  end

endmodule
